// File: rtl/shift_register_sequencer_pkg.sv
// Shared types and helpers for the shift register sequencer: FSM states,
// shift register direction encodings and the transfer length clamp.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] DIR_HOLD  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;

    // A length of zero or anything beyond the register width means a full word.
    function automatic int clamp_len(input int len, input int width);
        int result;
        if ((len == 0) || (len > width)) begin
            result = width;
        end else begin
            result = len;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_register_sequencer_if.sv
// Command/response handshake bundle between a requester and the sequencer.
// SHIFT_SEQ_ABORT_EN adds the abort request and the aborted response flag.
interface shift_register_sequencer_if #(
    parameter int WIDTH = 8
) ();
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_msb_first;
    logic [CNT_W-1:0] cmd_len;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             abort;
    logic             rsp_aborted;
`endif

    modport master (
        output cmd_valid, cmd_data, cmd_msb_first, cmd_len, rsp_ready,
`ifdef SHIFT_SEQ_ABORT_EN
        output abort,
        input  rsp_aborted,
`endif
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_msb_first, cmd_len, rsp_ready,
`ifdef SHIFT_SEQ_ABORT_EN
        input  abort,
        output rsp_aborted,
`endif
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/shift_register_sequencer_bit_counter.sv
// Loadable down-counter tracking the remaining shifts of a transfer; the
// terminal flag marks the last shift (count == 1).
module shift_seq_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    logic [CNT_W-1:0] r_count;

    // Count register: load wins over decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != {CNT_W{1'b0}})) begin
            r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_register_sequencer.sv
// Sequences an external universal shift register through load + N shifts per
// command. Optional feature macro: SHIFT_SEQ_ABORT_EN (early abort in SHIFT).
module shift_register_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DIRECTION_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    shift_register_sequencer_if.slave  bus,
    input  logic                       serial_in,
    output logic                       serial_out,
    output logic                       shift_strobe,
    output logic                       busy,
    output logic                       sr_enable,
    output logic                       sr_load,
    output logic [DIRECTION_WIDTH-1:0] sr_direction,
    output logic [WIDTH-1:0]           sr_parallel_in,
    output logic                       sr_serial_in_left,
    output logic                       sr_serial_in_right,
    input  logic [WIDTH-1:0]           sr_parallel_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_msb_first;
    logic             w_accept;
    logic             w_cnt_dec;
    logic             w_terminal;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_len_clamped;

    assign w_accept      = (r_state == IDLE) && bus.cmd_valid;
    assign w_len_clamped = CNT_W'(clamp_len(int'(bus.cmd_len), WIDTH));

    shift_seq_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (w_len_clamped),
        .i_dec      (w_cnt_dec),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    // State register and per-command bit order latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_msb_first <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_msb_first <= bus.cmd_msb_first;
            end else begin
                r_msb_first <= r_msb_first;
            end
        end
    end

`ifdef SHIFT_SEQ_ABORT_EN
    logic r_aborted;

    // Remember that the transfer ended early until the response is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aborted <= 1'b0;
        end else if ((r_state == SHIFT) && bus.abort) begin
            r_aborted <= 1'b1;
        end else if (w_accept) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= r_aborted;
        end
    end

    assign bus.rsp_aborted = (r_state == DONE) && r_aborted;
`endif

    // Next-state and datapath control decode.
    always_comb begin
        w_next_state       = r_state;
        w_cnt_dec          = 1'b0;
        bus.cmd_ready      = 1'b0;
        bus.rsp_valid      = 1'b0;
        bus.rsp_data       = {WIDTH{1'b0}};
        busy               = 1'b1;
        serial_out         = 1'b0;
        shift_strobe       = 1'b0;
        sr_enable          = 1'b0;
        sr_load            = 1'b0;
        sr_direction       = DIRECTION_WIDTH'(DIR_HOLD);
        sr_parallel_in     = {WIDTH{1'b0}};
        sr_serial_in_left  = 1'b0;
        sr_serial_in_right = 1'b0;
        case (r_state)
            IDLE: begin
                busy          = 1'b0;
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    sr_enable      = 1'b1;
                    sr_load        = 1'b1;
                    sr_parallel_in = bus.cmd_data;
                    w_next_state   = SHIFT;
                end else begin
                    w_next_state   = IDLE;
                end
            end
            SHIFT: begin
`ifdef SHIFT_SEQ_ABORT_EN
                if (bus.abort) begin
                    w_next_state = DONE;
                end else begin
`else
                begin
`endif
                    sr_enable    = 1'b1;
                    shift_strobe = 1'b1;
                    w_cnt_dec    = 1'b1;
                    if (r_msb_first) begin
                        sr_direction       = DIRECTION_WIDTH'(DIR_LEFT);
                        serial_out         = sr_parallel_out[WIDTH-1];
                        sr_serial_in_right = serial_in;
                    end else begin
                        sr_direction       = DIRECTION_WIDTH'(DIR_RIGHT);
                        serial_out         = sr_parallel_out[0];
                        sr_serial_in_left  = serial_in;
                    end
                    if (w_terminal || (w_count == {CNT_W{1'b0}})) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = SHIFT;
                    end
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = sr_parallel_out;
                if (bus.rsp_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Scoreboard bench: stimulus pushes expected serial bits and responses, a
// negedge monitor pops and compares; a behavioural shift register closes the loop.
module tb_shift_register_sequencer;
    localparam int WIDTH = 8;
    localparam int DW    = 2;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             aborted;
    } rsp_t;

    logic             clk;
    logic             rst_n;
    logic             serial_in;
    logic             serial_out;
    logic             shift_strobe;
    logic             busy;
    logic             sr_enable;
    logic             sr_load;
    logic [DW-1:0]    sr_direction;
    logic [WIDTH-1:0] sr_parallel_in;
    logic             sr_serial_in_left;
    logic             sr_serial_in_right;
    logic [WIDTH-1:0] sr_q;

    int   n_checks;
    int   n_fail;
    int   cycle;
    int   accept_cycle;
    int   exp_lat;
    logic [1:0] exp_dir;
    logic prev_valid;
    logic exp_bit_q[$];
    rsp_t rsp_q[$];

    shift_register_sequencer_if #(.WIDTH(WIDTH)) ifc ();

    shift_register_sequencer #(
        .WIDTH           (WIDTH),
        .DIRECTION_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus                (ifc.slave),
        .serial_in          (serial_in),
        .serial_out         (serial_out),
        .shift_strobe       (shift_strobe),
        .busy               (busy),
        .sr_enable          (sr_enable),
        .sr_load            (sr_load),
        .sr_direction       (sr_direction),
        .sr_parallel_in     (sr_parallel_in),
        .sr_serial_in_left  (sr_serial_in_left),
        .sr_serial_in_right (sr_serial_in_right),
        .sr_parallel_out    (sr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural universal shift register sharing the sequencer reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (sr_enable) begin
            if (sr_load) begin
                sr_q <= sr_parallel_in;
            end else if (sr_direction == 2'b01) begin
                sr_q <= {sr_serial_in_left, sr_q[WIDTH-1:1]};
            end else if (sr_direction == 2'b10) begin
                sr_q <= {sr_q[WIDTH-2:0], sr_serial_in_right};
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares serial bits on strobes and responses on handshake.
    always @(negedge clk) begin
        cycle++;
        if (rst_n) begin
            if (ifc.cmd_valid && ifc.cmd_ready) accept_cycle = cycle;
            if (shift_strobe) begin
                if (exp_bit_q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    check("serial_out", {31'd0, serial_out}, {31'd0, exp_bit_q.pop_front()});
                    check("sr_direction", {30'd0, sr_direction}, {30'd0, exp_dir});
                end
            end
            if (ifc.rsp_valid && !prev_valid)
                check("rsp_latency", cycle - accept_cycle, exp_lat);
            if (ifc.rsp_valid && ifc.rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("rsp_data", {24'd0, ifc.rsp_data}, {24'd0, e.data});
                    check("bits_left_at_rsp", exp_bit_q.size(), 32'd0);
`ifdef SHIFT_SEQ_ABORT_EN
                    check("rsp_aborted", {31'd0, ifc.rsp_aborted}, {31'd0, e.aborted});
`endif
                end
            end
            prev_valid = ifc.rsp_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic send_cmd(input logic [WIDTH-1:0] data, input logic msb,
                            input logic [CNT_W-1:0] len, input logic sin,
                            input int nbits, input logic [WIDTH-1:0] bits,
                            input logic [WIDTH-1:0] rdata, input logic ab, input int lat);
        rsp_t e;
        int t;
        t = 0;
        while (!ifc.cmd_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("cmd_ready_before_send", {31'd0, ifc.cmd_ready}, 32'd1);
        for (int i = nbits - 1; i >= 0; i--) exp_bit_q.push_back(bits[i]);
        e.data = rdata;
        e.aborted = ab;
        rsp_q.push_back(e);
        exp_dir = msb ? 2'b10 : 2'b01;
        exp_lat = lat;
        serial_in = sin;
        ifc.cmd_data = data;
        ifc.cmd_msb_first = msb;
        ifc.cmd_len = len;
        ifc.cmd_valid = 1'b1;
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_data = '0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((busy || rsp_q.size() != 0) && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("transfer_timeout", t < 100 ? 32'd0 : 32'd1, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, ifc.cmd_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, ifc.rsp_valid}, 32'd0);
        check({tag, "_rsp_data"}, {24'd0, ifc.rsp_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_strobe"}, {31'd0, shift_strobe}, 32'd0);
        check({tag, "_serial_out"}, {31'd0, serial_out}, 32'd0);
        check({tag, "_sr_enable"}, {31'd0, sr_enable}, 32'd0);
        check({tag, "_sr_load"}, {31'd0, sr_load}, 32'd0);
        check({tag, "_sr_dir"}, {30'd0, sr_direction}, 32'd0);
        check({tag, "_sr_pin"}, {24'd0, sr_parallel_in}, 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cycle = 0; accept_cycle = 0;
        exp_lat = 0; exp_dir = 2'b00; prev_valid = 1'b0;
        rst_n = 1'b0; serial_in = 1'b0;
        ifc.cmd_valid = 1'b0; ifc.cmd_data = '0; ifc.cmd_msb_first = 1'b0;
        ifc.cmd_len = '0; ifc.rsp_ready = 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
        ifc.abort = 1'b0;
`endif
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: 0xA5 MSB first, len 8, fill 1.
        send_cmd(8'hA5, 1'b1, 4'd8, 1'b1, 8, 8'b10100101, 8'hFF, 1'b0, 9);
        wait_done();
        // 2: 0x0F LSB first, len 8, fill 0.
        send_cmd(8'h0F, 1'b0, 4'd8, 1'b0, 8, 8'b11110000, 8'h00, 1'b0, 9);
        wait_done();
        // 3: partial transfer, then len 0 clamps to 8.
        send_cmd(8'hA5, 1'b1, 4'd3, 1'b0, 3, 8'b00000101, 8'h28, 1'b0, 4);
        wait_done();
        send_cmd(8'hA5, 1'b1, 4'd0, 1'b0, 8, 8'b10100101, 8'h00, 1'b0, 9);
        wait_done();
        // len above WIDTH also clamps to 8.
        send_cmd(8'h81, 1'b0, 4'd15, 1'b1, 8, 8'b10000001, 8'hFF, 1'b0, 9);
        wait_done();

        // 4: response stall; a stray command must be ignored.
        ifc.rsp_ready = 1'b0;
        send_cmd(8'h3C, 1'b0, 4'd2, 1'b1, 2, 8'b00000000, 8'hCF, 1'b0, 3);
        for (int t = 0; t < 20 && !ifc.rsp_valid; t++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd1);
            check("stall_rsp_data", {24'd0, ifc.rsp_data}, 32'hCF);
            check("stall_cmd_ready", {31'd0, ifc.cmd_ready}, 32'd0);
            ifc.cmd_valid = (i == 2);
            ifc.cmd_data = 8'h55;
            @(posedge clk); #1;
        end
        ifc.cmd_valid = 1'b0;
        ifc.cmd_data = '0;
        ifc.rsp_ready = 1'b1;
        wait_done();
        send_cmd(8'hC3, 1'b1, 4'd4, 1'b0, 4, 8'b00001100, 8'h30, 1'b0, 5);
        wait_done();

        // 5: reset after 4 shifts abandons the word.
        send_cmd(8'hA5, 1'b1, 4'd8, 1'b0, 8, 8'b10100101, 8'h00, 1'b0, 9);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_bit_q.delete();
        rsp_q.delete();
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_reset_cmd_ready", {31'd0, ifc.cmd_ready}, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        check("post_reset_idle", {31'd0, busy}, 32'd0);

`ifdef SHIFT_SEQ_ABORT_EN
        // 6: abort after two shifts.
        send_cmd(8'hA5, 1'b1, 4'd8, 1'b0, 2, 8'b00000010, 8'h94, 1'b1, 4);
        repeat (2) @(posedge clk);
        #1;
        ifc.abort = 1'b1;
        @(posedge clk); #1;
        ifc.abort = 1'b0;
        wait_done();
        send_cmd(8'h01, 1'b0, 4'd1, 1'b1, 1, 8'b00000001, 8'h80, 1'b0, 2);
        wait_done();
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/shift_register_sequencer.md
Name: shift_register_sequencer

Overview:
Controller that sequences a universal shift register through one serial word transfer per command. It accepts a parallel word over a valid/ready command interface and issues a load, then issues N shift cycles in the selected bit order. Each cycle it emits one bit on serial_out and inserts serial_in into the vacated end. It returns the final register contents over a valid/ready response interface. It sits between a requester (SPI-like master, test shifter) and the shift-register datapath, and owns that datapath's enable, load and direction controls.

Parameters:
WIDTH, 8, data/register width (>=2)
DIRECTION_WIDTH, 2, width of the shift register direction control
CNT_W, $clog2(WIDTH+1), localparam, width of the length field and the bit counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_data  in  WIDTH  word to load
cmd_msb_first  in  1  1: shift left, MSB out first; 0: shift right, LSB out first
cmd_len  in  CNT_W  number of shifts; 0 or >WIDTH clamps to WIDTH
serial_in  in  1  incoming bit, sampled on shift cycles
serial_out  out  1  outgoing bit, valid when shift_strobe=1, else 0
shift_strobe  out  1  high on each shift cycle
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed
rsp_data  out  WIDTH  register contents after the last shift
busy  out  1  high in any state except IDLE
sr_enable  out  1  to shift register enable
sr_load  out  1  to shift register load
sr_direction  out  DIRECTION_WIDTH  00 hold, 01 right, 10 left
sr_parallel_in  out  WIDTH  to shift register parallel input
sr_serial_in_left  out  1  MSB fill for right shift
sr_serial_in_right  out  1  LSB fill for left shift
sr_parallel_out  in  WIDTH  shift register contents

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, mode flag 0. All outputs 0 except cmd_ready=1. The shift register is reset by the same rst_n.
- Reset mid-transfer abandons the word. No rsp_valid is produced.
- Three states: IDLE, SHIFT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, in the same cycle: sr_enable=1, sr_load=1, sr_parallel_in=cmd_data. The register loads on that edge.
  - Latch msb_first. Latch the clamped length into the counter. Go to SHIFT.
- SHIFT:
  - cmd_ready=0, sr_enable=1, sr_load=0, shift_strobe=1.
  - sr_direction = 10 if msb_first, else 01.
  - serial_out = sr_parallel_out[WIDTH-1] if msb_first, else sr_parallel_out[0].
  - serial_in drives sr_serial_in_right when msb_first, else sr_serial_in_left. The unused fill input is 0.
  - The counter decrements each cycle. Shifting with counter==1 moves to DONE.
- DONE:
  - sr_enable=0, sr_direction=00, rsp_valid=1, rsp_data=sr_parallel_out (stable while stalled).
  - On rsp_ready, go to IDLE.
- Latency: command handshake in cycle 0, shifts in cycles 1..len, rsp_valid from cycle len+1.
- Minimum command-to-command spacing is len+2 cycles.
- Outside IDLE, cmd_valid is ignored and no command is lost (cmd_ready=0).
- sr_parallel_in=0 and sr_load=0 outside the IDLE accept cycle.

Optional Feature:
SHIFT_SEQ_ABORT_EN:
- Adds input abort (1b) and output rsp_aborted (1b).
- abort=1 in SHIFT suppresses that cycle's shift (sr_enable=0, shift_strobe=0) and moves to DONE.
- rsp_aborted=1 with the response; rsp_data holds the partially shifted value.
- abort is ignored in IDLE and DONE.
- Without the macro: no ports, and SHIFT always completes all len shifts.

Decomposition:
- Shared package shift_seq_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - direction constants DIR_HOLD=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10;
  - the length-clamp function.
- One natural sub-module: shift_seq_bit_counter, a loadable down-counter with a terminal flag (counter==1).
- The shift register datapath is instantiated beside this block, not inside it.

Test Plan:
1. cmd_data=0xA5, msb_first=1, len=8, serial_in=1 -> serial_out 1,0,1,0,0,1,0,1 on 8 strobes; rsp_data=0xFF; rsp_valid in cycle 9.
2. cmd_data=0x0F, msb_first=0, len=8, serial_in=0 -> serial_out 1,1,1,1,0,0,0,0; sr_direction=01 during SHIFT; rsp_data=0x00.
3. cmd_data=0xA5, msb_first=1, len=3, serial_in=0 -> serial_out 1,0,1; rsp_data=0x28; rsp_valid in cycle 4. Repeat with len=0 -> 8 strobes.
4. Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid and rsp_data stable, cmd_ready=0, a cmd_valid pulse is ignored. Then rsp_ready=1 -> IDLE, next command accepted.
5. Drop rst_n for 1 cycle after 4 shifts -> all outputs at reset values immediately, no rsp_valid, cmd_ready=1 after release.
6. (SHIFT_SEQ_ABORT_EN) 0xA5, msb_first=1, len=8, abort after 2 shifts -> rsp_aborted=1, rsp_data=0x94 with serial_in=0.
